slave_module: RTL and testbench
===============================

// Module: slave_module
// PURPOSE
// - I2C target (slave) bridging an external I2C bus to an 8-bit parallel CPU port.
// - Oversamples SCL/SDA on the system clock.
// - Written bytes appear on o_port (feeds CPU data input D0).
// - Read requests transmit the byte on i_port (driven by CPU output P0).
// - SDA is open-drain: d_out is ANDed externally with the master's SDA.
// PARAMETERS
// - ADDR  7'h3C  7-bit bus address this target responds to
// PORTS
// - clk     in   1  system clock; all logic on rising edge
// - rst     in   1  asynchronous, active-high reset
// - d_in    in   1  SDA as seen on the bus
// - d_out   out  1  SDA drive: 0 = pull low, 1 = released
// - c_in    in   1  SCL from the master
// - c_out   out  1  SCL drive; tied to 1 (released, no clock stretching)
// - o_port  out  8  last byte written by the master
// - i_port  in   8  byte returned to the master on reads
// BEHAVIOUR
// - Reset: d_out=1, c_out=1, o_port=8'h00, FSM=IDLE, bit counter=0, shift reg=0.
// - Input sampling: 2-FF synchronizer on d_in and c_in.
//   - Edges detected from synced previous/current values.
//   - Bus-to-internal event latency is 3 clk.
// - START: synced SDA 1->0 while SCL=1. Any state -> ADDR; counter cleared; d_out released.
//   - A repeated START behaves identically.
// - STOP: synced SDA 0->1 while SCL=1. Any state -> IDLE; d_out=1.
// - Data bits: sampled on SCL rising edge, MSB first.
// - Drive changes: d_out changes only on SCL falling edge, except STOP/START/reset, which release it immediately.
// - States: IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
// - ADDR:
//   - After 8th rising edge: if byte[7:1]==ADDR, latch R/W=byte[0] and go to ADDR_ACK.
//   - Otherwise go to IGNORE (d_out=1 until STOP/START).
// - ADDR_ACK:
//   - Next SCL fall: d_out=0.
//   - Following SCL fall: release.
//   - Next state: WR if R/W=0. If R/W=1: load i_port into shift reg, drive its MSB, go to RD.
// - WR:
//   - After 8th rising edge: o_port <= received byte (1 clk after edge detect); go to WR_ACK.
//   - o_port holds its value until the next complete byte; partial bytes never update it.
// - WR_ACK: same timing as ADDR_ACK; returns to WR for the next byte (unbounded burst).
// - RD:
//   - Shift on each SCL fall; 8 bits presented.
//   - On 8th fall after the MSB, release SDA and go to RD_ACK.
// - RD_ACK: sample master bit on SCL rise.
//   - 0 (ACK): at next fall, reload i_port and drive its MSB (RD).
//   - 1 (NACK): go to IGNORE.
// - i_port is captured only at load instants; later changes affect the next byte.
// - Bus glitches shorter than the synchronizer window are not guaranteed to be filtered
//   (see CONFIGURATION).
// - Simultaneous SCL and SDA change in the same synced sample: treated as a data edge,
//   not START/STOP.
// - Reset mid-transfer: immediate return to reset values; bus released.
// CONFIGURATION
// - GLITCH_FILTER_EN defined:
//   - Each synced input passes a 3-sample majority filter before edge detection.
//   - Event latency becomes 5 clk.
//   - Single-clk pulses on SCL/SDA are ignored.
// - GLITCH_FILTER_EN undefined: no filter; latency 3 clk.
// TESTING
// - Reset asserted mid-ACK -> d_out=1 and o_port=00 within 1 clk; FSM IDLE.
// - START, addr 0x78 (0x3C,W), data 0xA5, STOP -> ACK low on both 9th clocks; o_port=A5.
// - START, addr 0x7A (mismatch), data 0x11 -> d_out stays 1 for entire transfer;
//   o_port unchanged.
// - START, 0x79 (read), i_port=0xC3, master ACK, then i_port=0x5A, master NACK, STOP
//   -> SDA carries C3 then 5A, MSB first; released after NACK.
// - Write 0x12, repeated START, write 0x34 -> o_port=12 then 34; second address ACKed.
// - GLITCH_FILTER_EN set: 1-clk SCL pulse during a write -> no bit shifted; o_port unaffected.

Source files
------------

// File: rtl/slave_module.sv
// ---------------------------------------------------------------------------
// slave_module
// I2C target that bridges an external I2C bus to an 8-bit parallel CPU port.
// SCL and SDA are oversampled on clk through 2-FF synchronizers.
// Bytes written by the master appear on o_port.
// On a read, the byte on i_port is shifted out MSB first.
// SDA is open-drain: d_out = 0 pulls low, d_out = 1 releases the line.
// SCL is never stretched, so c_out is tied to 1.
//
// Optional build macro: GLITCH_FILTER_EN
//   Defined   : each synchronized input passes a 3-sample majority vote
//               before edge detection (bus event latency 5 clk).
//   Undefined : no filter (bus event latency 3 clk).
// ---------------------------------------------------------------------------
module slave_module #(
    parameter logic [6:0] ADDR = 7'h3C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_in,
    output logic       d_out,
    input  logic       c_in,
    output logic       c_out,
    output logic [7:0] o_port,
    input  logic [7:0] i_port
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WR       = 3'd3,
        S_WR_ACK   = 3'd4,
        S_RD       = 3'd5,
        S_RD_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

    // Channel 0 carries SDA and channel 1 carries SCL.
    // Both channels share the same conditioning chain.
    logic [1:0] w_raw;
    logic [1:0] w_cur;
    logic [1:0] r_prev;

    assign w_raw = {c_in, d_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_chan
            logic r_meta;
            logic r_sync;

            // Two-flop synchronizer; resets to the idle (released, high) bus level.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_meta <= 1'b1;
                    r_sync <= 1'b1;
                end else begin
                    r_meta <= w_raw[gi];
                    r_sync <= r_meta;
                end
            end

`ifdef GLITCH_FILTER_EN
            logic [2:0] r_hist;

            // Three-sample history; a majority vote rejects single-clk pulses.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hist <= 3'b111;
                end else begin
                    r_hist <= {r_hist[1:0], r_sync};
                end
            end

            assign w_cur[gi] = (r_hist[0] & r_hist[1]) |
                               (r_hist[0] & r_hist[2]) |
                               (r_hist[1] & r_hist[2]);
`else
            assign w_cur[gi] = r_sync;
`endif

            // Previous conditioned sample, used for edge detection.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_prev[gi] <= 1'b1;
                end else begin
                    r_prev[gi] <= w_cur[gi];
                end
            end
        end
    endgenerate

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_scl_stable_high;
    logic w_start;
    logic w_stop;

    assign w_sda             = w_cur[0];
    assign w_scl_rise        =  w_cur[1] & ~r_prev[1];
    assign w_scl_fall        = ~w_cur[1] &  r_prev[1];
    // START/STOP need SCL high in both the previous and current sample.
    // An SDA change in the same sample as an SCL change is a data edge.
    assign w_scl_stable_high =  w_cur[1] &  r_prev[1];
    assign w_start           =  r_prev[0] & ~w_sda & w_scl_stable_high;
    assign w_stop            = ~r_prev[0] &  w_sda & w_scl_stable_high;

    // FSM state and datapath registers.
    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_rw;
    logic       r_phase;    // ACK states: set once the ACK bit is on the bus / master ACK seen
    logic       r_wr_load;  // one-clk delayed strobe that copies a complete byte to o_port
    logic       r_d_out;
    logic [7:0] r_o_port;

    state_t     w_state_next;
    logic [3:0] w_bit_cnt_next;
    logic [7:0] w_shift_next;
    logic       w_rw_next;
    logic       w_phase_next;
    logic       w_wr_load_next;
    logic       w_d_out_next;
    logic [7:0] w_o_port_next;

    // State register plus all datapath registers; reset releases the bus at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_rw      <= 1'b0;
            r_phase   <= 1'b0;
            r_wr_load <= 1'b0;
            r_d_out   <= 1'b1;
            r_o_port  <= 8'h00;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_rw      <= w_rw_next;
            r_phase   <= w_phase_next;
            r_wr_load <= w_wr_load_next;
            r_d_out   <= w_d_out_next;
            r_o_port  <= w_o_port_next;
        end
    end

    // Next-state and datapath logic; START/STOP override every state.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_rw_next      = r_rw;
        w_phase_next   = r_phase;
        w_wr_load_next = 1'b0;
        w_d_out_next   = r_d_out;
        w_o_port_next  = r_o_port;

        // A completed write byte lands on o_port one clk after its 8th rising edge.
        if (r_wr_load) begin
            w_o_port_next = r_shift;
        end

        if (w_start) begin
            w_state_next   = S_ADDR;
            w_bit_cnt_next = 4'd0;
            w_phase_next   = 1'b0;
            w_d_out_next   = 1'b1;
        end else if (w_stop) begin
            w_state_next   = S_IDLE;
            w_bit_cnt_next = 4'd0;
            w_phase_next   = 1'b0;
            w_d_out_next   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_d_out_next = 1'b1;
                end

                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_next = {r_shift[6:0], w_sda};
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_next = 4'd0;
                            // The first seven bits received are the address; the eighth is R/W.
                            if (r_shift[6:0] == ADDR) begin
                                w_rw_next    = w_sda;
                                w_phase_next = 1'b0;
                                w_state_next = S_ADDR_ACK;
                            end else begin
                                w_state_next = S_IGNORE;
                            end
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 4'd1;
                        end
                    end
                end

                S_ADDR_ACK, S_WR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            // Pull SDA low for the whole 9th clock.
                            w_d_out_next = 1'b0;
                            w_phase_next = 1'b1;
                        end else begin
                            w_phase_next   = 1'b0;
                            w_bit_cnt_next = 4'd0;
                            if ((r_state == S_WR_ACK) || !r_rw) begin
                                w_d_out_next = 1'b1;
                                w_state_next = S_WR;
                            end else begin
                                w_shift_next = i_port;
                                w_d_out_next = i_port[7];
                                w_state_next = S_RD;
                            end
                        end
                    end
                end

                S_WR: begin
                    if (w_scl_rise) begin
                        w_shift_next = {r_shift[6:0], w_sda};
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_next = 4'd0;
                            w_wr_load_next = 1'b1;
                            w_phase_next   = 1'b0;
                            w_state_next   = S_WR_ACK;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 4'd1;
                        end
                    end
                end

                S_RD: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd7) begin
                            // All eight bits have been presented; free SDA for the master's ACK.
                            w_d_out_next   = 1'b1;
                            w_bit_cnt_next = 4'd0;
                            w_phase_next   = 1'b0;
                            w_state_next   = S_RD_ACK;
                        end else begin
                            w_shift_next   = {r_shift[6:0], 1'b0};
                            w_d_out_next   = r_shift[6];
                            w_bit_cnt_next = r_bit_cnt + 4'd1;
                        end
                    end
                end

                S_RD_ACK: begin
                    if (w_scl_rise && !r_phase) begin
                        if (!w_sda) begin
                            w_phase_next = 1'b1;
                        end else begin
                            w_d_out_next = 1'b1;
                            w_state_next = S_IGNORE;
                        end
                    end else if (w_scl_fall && r_phase) begin
                        // The master ACKed, so capture a fresh i_port byte and present its MSB.
                        w_shift_next   = i_port;
                        w_d_out_next   = i_port[7];
                        w_bit_cnt_next = 4'd0;
                        w_phase_next   = 1'b0;
                        w_state_next   = S_RD;
                    end
                end

                S_IGNORE: begin
                    w_d_out_next = 1'b1;
                end

                default: begin
                    w_state_next = S_IDLE;
                    w_d_out_next = 1'b1;
                end
            endcase
        end
    end

    assign d_out  = r_d_out;
    assign c_out  = 1'b1;
    assign o_port = r_o_port;

endmodule

// File: tb/tb_slave_module.sv
// ---------------------------------------------------------------------------
// tb_slave_module
// Bus-level bench for slave_module.
// A behavioural I2C master drives SCL and SDA. SDA is wired-AND with d_out.
// Expected ACK bits, read data and o_port values are pushed to a scoreboard
// queue when the stimulus is issued, then popped when the DUT's response is
// sampled.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_slave_module;

    localparam int Q = 5;   // clk from SCL fall to SDA change (and SDA change to SCL rise)
    localparam int H = 10;  // SCL high time in clk

    logic       clk = 1'b0;
    logic       rst;
    logic       m_sda;
    logic       m_scl;
    logic       sda_bus;
    logic       d_out;
    logic       c_out;
    logic [7:0] o_port;
    logic [7:0] i_port;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int watch_rel = 0;
    int rel_viol = 0;

    assign sda_bus = m_sda & d_out;

    always #5 clk = ~clk;

    slave_module #(.ADDR(7'h3C)) dut (
        .clk    (clk),
        .rst    (rst),
        .d_in   (sda_bus),
        .d_out  (d_out),
        .c_in   (m_scl),
        .c_out  (c_out),
        .o_port (o_port),
        .i_port (i_port)
    );

    // Count any clk on which the target pulls SDA low while it is supposed to stay silent.
    always @(negedge clk) begin
        if (watch_rel != 0 && d_out !== 1'b1) rel_viol++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop_check(input string tag, input int obs);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(H);
        m_sda = 1'b0; wait_clk(H);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(H);
        m_sda = 1'b1; wait_clk(H);
    endtask

    // One data bit; with glitch set, a 1-clk SCL pulse is inserted in the low phase.
    task automatic send_bit(input logic b, input logic glitch);
        m_sda = b;
        if (glitch) begin
            wait_clk(2); m_scl = 1'b1;
            wait_clk(1); m_scl = 1'b0;
            wait_clk(Q - 3);
        end else begin
            wait_clk(Q);
        end
        m_scl = 1'b1; wait_clk(H);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input string tag, input logic [7:0] data,
                              input int exp_ack, input int glitch_bit);
        exp_q.push_back(exp_ack);
        for (int i = 7; i >= 0; i--) send_bit(data[i], (i == glitch_bit));
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(H / 2);
        sb_pop_check(tag, sda_bus);
        wait_clk(H / 2);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp_data,
                             input logic master_ack, input int change_iport,
                             input logic [7:0] new_iport);
        logic [7:0] val;
        val = 8'h00;
        exp_q.push_back(exp_data);
        for (int i = 0; i < 8; i++) begin
            m_sda = 1'b1; wait_clk(Q);
            m_scl = 1'b1; wait_clk(H / 2);
            val = {val[6:0], sda_bus};
            if (i == 0 && change_iport != 0) i_port = new_iport;
            wait_clk(H / 2);
            m_scl = 1'b0; wait_clk(Q);
        end
        sb_pop_check(tag, val);
        m_sda = master_ack; wait_clk(Q);
        m_scl = 1'b1; wait_clk(H / 2);
        check({tag, "_rel"}, d_out, 1);
        wait_clk(H / 2);
        m_scl = 1'b0; wait_clk(Q);
        m_sda = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; m_sda = 1'b1; m_scl = 1'b1; i_port = 8'h00;
        wait_clk(4);
        check("rst_d_out", d_out, 1);
        check("rst_c_out", c_out, 1);
        check("rst_o_port", o_port, 8'h00);
        rst = 1'b0;
        wait_clk(4);
        $display("TXN reset released d_out=%0b o_port=%02h", d_out, o_port);

        // Write 0xA5 to 0x3C.
        bus_start();
        write_byte("wr_addr_ack", 8'h78, 0, -1);
        write_byte("wr_data_ack", 8'hA5, 0, -1);
        bus_stop();
        exp_q.push_back(8'hA5);
        sb_pop_check("wr_o_port", o_port);
        $display("TXN write addr=78 data=A5 o_port=%02h", o_port);

        // Address mismatch: the target must stay silent and o_port must not change.
        watch_rel = 1;
        bus_start();
        write_byte("mis_addr_nack", 8'h7A, 1, -1);
        write_byte("mis_data_nack", 8'h11, 1, -1);
        bus_stop();
        watch_rel = 0;
        check("mis_sda_low_clks", rel_viol, 0);
        exp_q.push_back(8'hA5);
        sb_pop_check("mis_o_port", o_port);
        $display("TXN write addr=7A data=11 (not addressed) o_port=%02h", o_port);

        // Read C3 (ACK), then 5A (NACK). i_port changes mid-byte and takes effect on the next byte.
        i_port = 8'hC3;
        bus_start();
        write_byte("rd_addr_ack", 8'h79, 0, -1);
        read_byte("rd_byte0", 8'hC3, 1'b0, 1, 8'h5A);
        read_byte("rd_byte1", 8'h5A, 1'b1, 0, 8'h00);
        wait_clk(Q);
        check("rd_nack_released", d_out, 1);
        bus_stop();
        $display("TXN read addr=79 data=C3,5A");

        // Write 0x12, repeated START, then write 0x34.
        bus_start();
        write_byte("rs_addr0_ack", 8'h78, 0, -1);
        write_byte("rs_data0_ack", 8'h12, 0, -1);
        wait_clk(2);
        exp_q.push_back(8'h12);
        sb_pop_check("rs_o_port0", o_port);
        bus_start();
        write_byte("rs_addr1_ack", 8'h78, 0, -1);
        write_byte("rs_data1_ack", 8'h34, 0, -1);
        bus_stop();
        exp_q.push_back(8'h34);
        sb_pop_check("rs_o_port1", o_port);
        $display("TXN write 12, repeated start, write 34 o_port=%02h", o_port);

        // Reset asserted while the address ACK is driven.
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(((8'h78 >> i) & 8'h01) != 8'h00, 1'b0);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(H / 2);
        check("rst_mid_ack_low", d_out, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_d_out", d_out, 1);
        check("rst_mid_o_port", o_port, 8'h00);
        wait_clk(2);
        rst = 1'b0;
        wait_clk(H / 2);
        m_scl = 1'b0; wait_clk(Q);
        bus_stop();
        $display("TXN reset during address ACK d_out=%0b o_port=%02h", d_out, o_port);

        // Recovery from IDLE after reset.
        bus_start();
        write_byte("post_rst_addr_ack", 8'h78, 0, -1);
        write_byte("post_rst_data_ack", 8'h5C, 0, -1);
        bus_stop();
        exp_q.push_back(8'h5C);
        sb_pop_check("post_rst_o_port", o_port);
        $display("TXN write addr=78 data=5C o_port=%02h", o_port);

`ifdef GLITCH_FILTER_EN
        // A 1-clk SCL pulse inside a data bit must not shift an extra bit.
        bus_start();
        write_byte("glitch_addr_ack", 8'h78, 0, -1);
        write_byte("glitch_data_ack", 8'h96, 0, 3);
        bus_stop();
        exp_q.push_back(8'h96);
        sb_pop_check("glitch_o_port", o_port);
        $display("TXN write addr=78 data=96 with SCL glitch o_port=%02h", o_port);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
